axis_packet_tx: RTL and testbench
=================================

// Module: axis_packet_tx
// PURPOSE
//  AXI-Stream master/transmitter: the driving end of the 64-bit TDATA/TVALID/TLAST/TREADY stream.
//  Buffers words from a simple push port in a FIFO and forms packets of runtime length pkt_len.
//  Generates TLAST, holds TVALID/TDATA/TLAST stable under backpressure. Must never trip the stream protocol checker.
// PARAMETERS
//  DEPTH    8    FIFO entries; power of 2, >=2
//  LEN_W    16   width of pkt_len and the beat counter
// PORTS
//  clk         in   1      clock, all logic on posedge
//  rst         in   1      synchronous, active-high reset
//  s_valid     in   1      push request
//  s_data      in   64     push word
//  s_ready     out  1      = !fifo_full; push accepted when s_valid && s_ready
//  pkt_len     in   LEN_W  beats per packet; 0 treated as 1
//  m_tdata     out  64     stream payload (registered)
//  m_tvalid    out  1      stream valid (registered)
//  m_tlast     out  1      last beat of packet (registered)
//  m_tready    in   1      stream ready from sink
//  busy        out  1      FIFO non-empty || m_tvalid || state==MID
//  fifo_level  out  $clog2(DEPTH)+1  FIFO occupancy, excluding output register
// BEHAVIOUR
//  - Reset values: m_tvalid=0, m_tlast=0, m_tdata=0, s_ready=1, busy=0, fifo_level=0, state=IDLE, beat_idx=0.
//  - FIFO: write on s_valid&&s_ready; no write when full. Read/write in same cycle allowed (level unchanged).
//    Pointers wrap modulo DEPTH; extra MSB distinguishes full/empty.
//  - Output register load condition: fifo non-empty && (!m_tvalid || m_tready).
//    A handshake with no load clears m_tvalid. m_tvalid never drops without a handshake.
//    m_tdata and m_tlast never change while m_tvalid && !m_tready.
//  - Latency: word accepted at edge N is on m_tvalid from edge N+1 if the register is free
//    (FIFO write at edge N, load at edge N+1). Full throughput: 1 beat/cycle with m_tready=1.
//  - Capacity: DEPTH words in FIFO + 1 in output register.
//  - FSM, advanced on each load (not on handshake):
//    IDLE: next load is beat 0; latch len = (pkt_len==0 ? 1 : pkt_len).
//          len==1 -> m_tlast=1, stay IDLE; else beat_idx=1, go MID.
//    MID:  m_tlast = (beat_idx == len-1). On last: beat_idx=0, go IDLE; else beat_idx++.
//  - pkt_len is sampled only at beat 0; changes mid-packet take effect next packet.
//  - LEN_W arithmetic is unsigned; len-1 never underflows because len>=1.
//  - Reset mid-packet: FIFO flushed, partial packet dropped without TLAST, m_tvalid=0 after the edge.
//    Next load starts at beat 0. The sink is responsible for resynchronising.
// CONFIGURATION
//  AXIS_TX_STATS_EN defined:
//    Adds out ports pkt_count[31:0] and beat_count[31:0], reset 0.
//    beat_count++ on each handshake; pkt_count++ on each handshake with m_tlast. Both wrap at 2^32.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. pkt_len=4, m_tready=1, push 0..7 back-to-back -> beats 0..7 in order, one per cycle;
//     m_tlast only on 3 and 7; first m_tvalid 1 cycle after first accept.
//  2. Mid-packet, hold m_tready=0 for 10 cycles -> m_tvalid stays 1; m_tdata/m_tlast unchanged;
//     stream resumes with no loss or duplication.
//  3. DEPTH=8, m_tready=0, push 12 words -> exactly 9 accepted; s_ready=0, fifo_level=8.
//     After one handshake, s_ready=1 the next cycle.
//  4. pkt_len=0 -> every beat has m_tlast=1. Change pkt_len 3->5 during beat 1 -> that packet
//     ends after 3 beats, the next after 5.
//  5. Assert rst for 1 cycle during beat 2 of a 6-beat packet -> m_tvalid=0, fifo_level=0, busy=0.
//     New pushes form a fresh packet with TLAST on its 6th beat.
//  6. AXIS_TX_STATS_EN, pkt_len=3, 9 beats with random m_tready -> beat_count=9, pkt_count=3.

Source files
------------

// File: rtl/axis_packet_tx.sv
// axis_packet_tx: 64-bit AXI-Stream transmitter.
// A push port fills a DEPTH-entry FIFO. A registered output stage drives
// m_tdata/m_tvalid/m_tlast, and a small FSM cuts the beat stream into packets
// of pkt_len beats.
// Optional feature: define AXIS_TX_STATS_EN to add the pkt_count and
// beat_count output ports.
//
// Handshake rules:
//   - s_valid/s_ready:
//       A word is accepted on a rising edge where s_valid && s_ready.
//       s_ready is simply "FIFO not full".
//   - m_tvalid/m_tready:
//       A beat transfers on a rising edge where m_tvalid && m_tready.
//       Once m_tvalid is high, m_tvalid, m_tdata and m_tlast hold their values
//       until that transfer happens.
//       After a transfer, the output register either reloads from the FIFO
//       or drops m_tvalid.
module axis_packet_tx #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  input  logic [63:0]              s_data,
  output logic                     s_ready,
  input  logic [LEN_W-1:0]         pkt_len,
  output logic [63:0]              m_tdata,
  output logic                     m_tvalid,
  output logic                     m_tlast,
  input  logic                     m_tready,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     state_dbg
`ifdef AXIS_TX_STATS_EN
  ,
  output logic [31:0]              pkt_count,
  output logic [31:0]              beat_count
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    MID  = 1'b1
  } state_t;

  logic [63:0]      mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             fifo_empty, fifo_full;
  logic             push, load, handshake;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_idx_q, beat_idx_d;
  logic [LEN_W-1:0] eff_len;
  logic             last_beat;

  logic [63:0]      tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;

  // FIFO status and the three events that drive every register.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    push       = s_valid && !fifo_full;
    load       = !fifo_empty && (!tvalid_q || m_tready);
    handshake  = tvalid_q && m_tready;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = load ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  // FIFO pointers; the extra MSB separates full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage. It needs no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= s_data;
    end
  end

  // Packet FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      beat_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      beat_idx_q <= beat_idx_d;
    end
  end

  // Packet FSM next state. It advances only when a word is loaded into the
  // output register, so backpressure never moves it.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    beat_idx_d = beat_idx_q;
    if (load) begin
      case (state_q)
        IDLE: begin
          len_d = eff_len;
          if (eff_len != LEN_W'(1)) begin
            beat_idx_d = LEN_W'(1);
            state_d    = MID;
          end
        end
        MID: begin
          if (beat_idx_q == len_q - LEN_W'(1)) begin
            beat_idx_d = '0;
            state_d    = IDLE;
          end else begin
            beat_idx_d = beat_idx_q + LEN_W'(1);
          end
        end
        default: begin
          beat_idx_d = '0;
          state_d    = IDLE;
        end
      endcase
    end
  end

  // Packet FSM outputs.
  // In IDLE, the live pkt_len sets the length of the packet about to start.
  // In MID, the length latched at beat 0 is used.
  always_comb begin
    eff_len   = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
    last_beat = 1'b0;
    case (state_q)
      IDLE:    last_beat = (eff_len == LEN_W'(1));
      MID:     last_beat = (beat_idx_q == len_q - LEN_W'(1));
      default: last_beat = 1'b0;
    endcase
  end

  // Output register next state.
  // - A load takes the FIFO head.
  // - A transfer with nothing to load retires the beat.
  // - Otherwise every field holds.
  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    if (load) begin
      tdata_d  = mem_q[rd_ptr_q[AW-1:0]];
      tvalid_d = 1'b1;
      tlast_d  = last_beat;
    end else if (handshake) begin
      tvalid_d = 1'b0;
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

`ifdef AXIS_TX_STATS_EN
  logic [31:0] pkt_count_q, beat_count_q;

  // Transfer statistics; both counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count_q  <= '0;
      beat_count_q <= '0;
    end else if (handshake) begin
      beat_count_q <= beat_count_q + 32'd1;
      if (tlast_q) begin
        pkt_count_q <= pkt_count_q + 32'd1;
      end
    end
  end

  assign pkt_count  = pkt_count_q;
  assign beat_count = beat_count_q;
`endif

  // Port mapping for the status outputs.
  always_comb begin
    s_ready    = !fifo_full;
    m_tdata    = tdata_q;
    m_tvalid   = tvalid_q;
    m_tlast    = tlast_q;
    busy       = !fifo_empty || tvalid_q || (state_q == MID);
    fifo_level = wr_ptr_q - rd_ptr_q;
    state_dbg  = state_q;
  end

endmodule

// File: tb/tb_axis_packet_tx.sv
// Bench for axis_packet_tx.
// The reference model holds the accepted words in a queue, plus one output
// slot and a packet position counter.
// A compare process checks every DUT output against the model on each
// falling edge.
// Directed scenarios add literal checks on the beat stream seen at the sink.
module tb_axis_packet_tx;
  localparam int DEPTH = 8;
  localparam int LEN_W = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic [63:0]      s_data;
  logic             s_ready;
  logic [LEN_W-1:0] pkt_len;
  logic [63:0]      m_tdata;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tready;
  logic             busy;
  logic [LW-1:0]    fifo_level;
  logic             state_dbg;
`ifdef AXIS_TX_STATS_EN
  logic [31:0]      pkt_count;
  logic [31:0]      beat_count;
`endif

  axis_packet_tx #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .pkt_len    (pkt_len),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .busy       (busy),
    .fifo_level (fifo_level),
    .state_dbg  (state_dbg)
`ifdef AXIS_TX_STATS_EN
    ,
    .pkt_count  (pkt_count),
    .beat_count (beat_count)
`endif
  );

  // Clock.
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model.
  // exp_q holds the words waiting in the FIFO.
  // mv/md/ml describe the output slot.
  // pos is the beat position within the current packet.
  logic [63:0] exp_q[$];
  bit          mv;
  logic [63:0] md;
  bit          ml;
  int          pos;
  int          cur_len;
  int          m_beats;
  int          m_pkts;
  bit          hs_m;
  bit          ld_m;
  bit          push_m;

  initial begin
    mv = 0; md = '0; ml = 0; pos = 0; cur_len = 1; m_beats = 0; m_pkts = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        mv = 0; md = '0; ml = 0; pos = 0; m_beats = 0; m_pkts = 0;
      end else begin
        hs_m   = mv && m_tready;
        ld_m   = (exp_q.size() > 0) && (!mv || m_tready);
        push_m = s_valid && (exp_q.size() < DEPTH);
        if (hs_m) begin
          m_beats++;
          if (ml) m_pkts++;
        end
        if (ld_m) begin
          if (pos == 0) cur_len = (pkt_len == 0) ? 1 : int'(pkt_len);
          md  = exp_q.pop_front();
          ml  = (pos == cur_len - 1);
          pos = ml ? 0 : pos + 1;
          mv  = 1;
        end else if (hs_m) begin
          mv = 0;
        end
        if (push_m) exp_q.push_back(s_data);
      end
    end
  end

  // Sink-side log of transferred beats, and a count of accepted pushes.
  logic [63:0] dut_d[$];
  bit          dut_l[$];
  int          acc_cnt;
  bit          cmp_en = 0;

  // Compare process: falling edge, well away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("s_ready",    64'(s_ready),    64'(exp_q.size() < DEPTH));
        check("fifo_level", 64'(fifo_level), 64'(exp_q.size()));
        check("m_tvalid",   64'(m_tvalid),   64'(mv));
        if (mv) begin
          check("m_tdata", m_tdata,        md);
          check("m_tlast", 64'(m_tlast),   64'(ml));
        end
        check("busy",       64'(busy),       64'((exp_q.size() > 0) || mv || (pos != 0)));
        check("state_mid",  64'(state_dbg),  64'(pos != 0));
`ifdef AXIS_TX_STATS_EN
        check("beat_count", 64'(beat_count), 64'(m_beats));
        check("pkt_count",  64'(pkt_count),  64'(m_pkts));
`endif
        if (m_tvalid && m_tready) begin
          dut_d.push_back(m_tdata);
          dut_l.push_back(m_tlast);
        end
        if (s_valid && s_ready) acc_cnt++;
      end
    end
  end

  // Driver tasks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    dut_d.delete();
    dut_l.delete();
    acc_cnt = 0;
  endtask

  task automatic drain(input string tag, input bit rnd);
    int n = 0;
    while (busy && n < 200) begin
      if (rnd) m_tready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check(tag, 64'(busy), 64'(0));
  endtask

  task automatic push_wait(input logic [63:0] d);
    int n = 0;
    logic was;
    s_valid = 1'b1;
    s_data  = d;
    do begin
      was      = s_ready;
      m_tready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end while (!was && n < 100);
    check("push_wait_accept", 64'(was), 64'(1));
    s_valid = 1'b0;
  endtask

  task automatic check_log(input string tag, input int n, input int base, input logic [15:0] mask);
    check({tag, "_count"}, 64'(dut_d.size()), 64'(n));
    for (int k = 0; k < n; k++) begin
      check({tag, "_data"}, dut_d[k],      64'(base + k));
      check({tag, "_last"}, 64'(dut_l[k]), 64'(mask[k]));
    end
  endtask

  // Directed scenarios.
  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; pkt_len = 16'd4; m_tready = 1'b0;
    acc_cnt = 0;
    tick(); tick();
    cmp_en = 1;
    check("rst_m_tvalid",   64'(m_tvalid),   64'(0));
    check("rst_m_tlast",    64'(m_tlast),    64'(0));
    check("rst_m_tdata",    m_tdata,         64'(0));
    check("rst_s_ready",    64'(s_ready),    64'(1));
    check("rst_busy",       64'(busy),       64'(0));
    check("rst_fifo_level", 64'(fifo_level), 64'(0));
    check("rst_state",      64'(state_dbg),  64'(0));
    rst = 1'b0;

    // Scenario 1: pkt_len=4, back-to-back pushes 0..7, sink always ready.
    m_tready = 1'b1; pkt_len = 16'd4; clear_logs();
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_data = 64'(i);
      tick();
      if (i == 0) check("t1_latency_edge0", 64'(m_tvalid), 64'(0));
      if (i == 1) begin
        check("t1_latency_edge1", 64'(m_tvalid), 64'(1));
        check("t1_first_data",    m_tdata,       64'(0));
      end
    end
    s_valid = 1'b0;
    drain("t1_drain", 0);
    check_log("t1", 8, 0, 16'h0088);

    // Scenario 2: 10-cycle stall while beat 1 (word 101) is presented.
    m_tready = 1'b1; clear_logs();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) m_tready = 1'b0;
      s_valid = 1'b1; s_data = 64'(100 + i);
      tick();
      if (i >= 3) begin
        check("t2_stall_valid", 64'(m_tvalid), 64'(1));
        check("t2_stall_data",  m_tdata,       64'(101));
        check("t2_stall_last",  64'(m_tlast),  64'(0));
      end
    end
    s_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_stall_valid", 64'(m_tvalid), 64'(1));
      check("t2_stall_data",  m_tdata,       64'(101));
      check("t2_stall_last",  64'(m_tlast),  64'(0));
    end
    m_tready = 1'b1;
    drain("t2_drain", 0);
    check_log("t2", 8, 100, 16'h0088);

    // Scenario 3: capacity. Sink stalled, 12 push attempts, only 9 accepted.
    pkt_len = 16'd3; m_tready = 1'b0; clear_logs();
    for (int i = 0; i < 12; i++) begin
      s_valid = 1'b1; s_data = 64'(200 + i);
      tick();
    end
    s_valid = 1'b0;
    check("t3_accepted",  64'(acc_cnt),    64'(9));
    check("t3_s_ready",   64'(s_ready),    64'(0));
    check("t3_level",     64'(fifo_level), 64'(8));
    check("t3_out_data",  m_tdata,         64'(200));
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    check("t3_ready_back", 64'(s_ready),    64'(1));
    check("t3_level_7",    64'(fifo_level), 64'(7));
    check("t3_next_data",  m_tdata,         64'(201));
    m_tready = 1'b1;
    drain("t3_drain", 0);
    check_log("t3", 9, 200, 16'h0124);

    // Scenario 4a: pkt_len=0 behaves as single-beat packets.
    pkt_len = 16'd0; m_tready = 1'b1; clear_logs();
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 64'(300 + i);
      tick();
    end
    s_valid = 1'b0;
    drain("t4a_drain", 0);
    check_log("t4a", 4, 300, 16'h000F);

    // Scenario 4b: pkt_len changes 3->5 during beat 1. That packet is 3 beats,
    // the next one is 5.
    pkt_len = 16'd3; clear_logs();
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_data = 64'(400 + i);
      tick();
      if (i == 2) pkt_len = 16'd5;
    end
    s_valid = 1'b0;
    drain("t4b_drain", 0);
    check_log("t4b", 8, 400, 16'h0084);

    // Scenario 5: reset during beat 2 of a 6-beat packet, then a fresh start.
    pkt_len = 16'd6; m_tready = 1'b1; clear_logs();
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 64'(500 + i);
      tick();
    end
    check("t5_beat2_data", m_tdata, 64'(502));
    s_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_tvalid", 64'(m_tvalid),   64'(0));
    check("t5_rst_level",  64'(fifo_level), 64'(0));
    check("t5_rst_busy",   64'(busy),       64'(0));
    check("t5_rst_state",  64'(state_dbg),  64'(0));
    clear_logs();
    for (int i = 0; i < 12; i++) begin
      s_valid = 1'b1; s_data = 64'(600 + i);
      tick();
    end
    s_valid = 1'b0;
    drain("t5_drain", 0);
    check_log("t5", 12, 600, 16'h0820);

    // Scenario 6: pkt_len=3, 9 beats under a random sink.
    pkt_len = 16'd3; clear_logs();
    for (int i = 0; i < 9; i++) push_wait(64'(700 + i));
    drain("t6_drain", 1);
    check_log("t6", 9, 700, 16'h0124);
    check("t6_model_beats", 64'(m_beats), 64'(21));
    check("t6_model_pkts",  64'(m_pkts),  64'(5));
`ifdef AXIS_TX_STATS_EN
    check("t6_beat_count", 64'(beat_count), 64'(21));
    check("t6_pkt_count",  64'(pkt_count),  64'(5));
`endif

    m_tready = 1'b1;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
